// File: rtl/inst_fetch.sv
// inst_fetch: PC, single-cycle ROM read tracking, 2-entry decode FIFO, redirect flush.
// Ports: clk, rst_n, imem_addr/imem_inst (ROM), redirect_valid/redirect_pc (execute),
//   dec_valid/dec_ready/dec_inst/dec_pc (decode).
//   Optional INST_FETCH_PERF_EN adds perf_issued, perf_stall, perf_flush.
module inst_fetch #(
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [29:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [29:0] dec_pc
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    logic [29:0] pc;
    logic        inflight;
    logic [29:0] inflight_pc;
    logic [31:0] q_inst [2];
    logic [29:0] q_pc   [2];
    logic [1:0]  count;

    logic        pop;
    logic [2:0]  occ;
    logic        issue;
    logic [1:0]  count_nxt;
    logic [1:0]  slot;

    always_comb begin
        pop       = dec_valid & dec_ready;
        // occupancy once this cycle's pop and pending push settle
        occ       = {1'b0, count} - {2'b0, pop} + {2'b0, inflight};
        issue     = (occ < 3'd2);
        count_nxt = count - {1'b0, pop} + {1'b0, inflight};
        // push lands behind whatever survives the pop
        slot      = count - {1'b0, pop};
        imem_addr = redirect_valid ? redirect_pc : pc;
        dec_valid = (count != 2'd0);
        dec_inst  = dec_valid ? q_inst[0] : 32'h0;
        dec_pc    = dec_valid ? q_pc[0] : 30'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 30'h0;
            count       <= 2'd0;
            q_inst[0]   <= 32'h0;
            q_inst[1]   <= 32'h0;
            q_pc[0]     <= 30'h0;
            q_pc[1]     <= 30'h0;
        end else if (redirect_valid) begin
            count       <= 2'd0;
            inflight    <= 1'b1;
            inflight_pc <= redirect_pc;
            pc          <= redirect_pc + 30'd1;
        end else begin
            if (pop) begin
                q_inst[0] <= q_inst[1];
                q_pc[0]   <= q_pc[1];
            end
            if (inflight) begin
                if (slot == 2'd0) begin
                    q_inst[0] <= imem_inst;
                    q_pc[0]   <= inflight_pc;
                end else begin
                    q_inst[1] <= imem_inst;
                    q_pc[1]   <= inflight_pc;
                end
            end
            count <= count_nxt;
            if (issue) begin
                pc          <= pc + 30'd1;
                inflight    <= 1'b1;
                inflight_pc <= pc;
            end else begin
                inflight <= 1'b0;
            end
        end
    end

`ifdef INST_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= 32'h0;
            perf_stall  <= 32'h0;
            perf_flush  <= 32'h0;
        end else begin
            if (redirect_valid | issue)
                perf_issued <= perf_issued + 32'd1;
            if (dec_valid & ~dec_ready)
                perf_stall <= perf_stall + 32'd1;
            if (redirect_valid)
                perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule
